// File: rtl/line_burst_adaptor.sv
// Bridges a single-transaction cacheline port to a fixed-length beat burst port:
// writes are serialised into beats, read beats are assembled into a full line.
module line_burst_adaptor #(
    parameter int LINE_W   = 256,
    parameter int BURST_W  = 64,
    parameter int OFFSET_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_read_i,
    input  logic               line_write_i,
    input  logic [31:0]        line_addr_i,
    input  logic [LINE_W-1:0]  line_wdata_i,
    output logic [LINE_W-1:0]  line_rdata_o,
    output logic               line_resp_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BURST_W-1:0] mem_wdata_o,
    input  logic [BURST_W-1:0] mem_rdata_i,
    input  logic               mem_resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic [31:0] ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   buf_q, buf_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
        end
    end

    // buf_q holds the write line, or accumulates read beats; rdata_q only
    // changes when a read line is complete so the L2 sees a stable value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (line_write_i) begin
                    state_d = WRITE;
                    addr_d  = line_addr_i & ADDR_MASK;
                    buf_d   = line_wdata_i;
                    cnt_d   = '0;
                end else if (line_read_i) begin
                    state_d = READ;
                    addr_d  = line_addr_i & ADDR_MASK;
                    cnt_d   = '0;
                end
            end
            READ: begin
                if (mem_resp_i) begin
                    buf_d[BURST_W*int'(cnt_q) +: BURST_W] = mem_rdata_i;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                        rdata_d = buf_d;
                    end
                end
            end
            WRITE: begin
                if (mem_resp_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        line_resp_o = 1'b0;
        case (state_q)
            READ: begin
                mem_read_o = 1'b1;
                mem_addr_o = addr_q;
            end
            WRITE: begin
                mem_write_o = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = buf_q[BURST_W*int'(cnt_q) +: BURST_W];
            end
            DONE:    line_resp_o = 1'b1;
            default: ;
        endcase
    end

    assign line_rdata_o = rdata_q;

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench for line_burst_adaptor: directed scenarios plus randomized
// read/write traffic with random memory stalls against a line-level model.
module tb_line_burst_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         line_read_i, line_write_i;
    logic [31:0]  line_addr_i;
    logic [255:0] line_wdata_i;
    logic [255:0] line_rdata_o;
    logic         line_resp_o;
    logic         mem_read_o, mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [63:0]  mem_wdata_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_resp_i;

    int total = 0;
    int bad   = 0;
    logic [255:0] line_model;

    line_burst_adaptor dut (
        .clk(clk), .rst(rst),
        .line_read_i(line_read_i), .line_write_i(line_write_i),
        .line_addr_i(line_addr_i), .line_wdata_i(line_wdata_i),
        .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Acts as the L2 and the memory for one transaction. Records what the
    // memory side saw (accepted write beats, address, strobes) and how many
    // cycles after the request the completion pulse appeared.
    task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wline, input logic [255:0] rline,
                           input int stall_pct,
                           output logic [255:0] wseen, output logic [31:0] aseen,
                           output int ncyc, output int nresp, output int extra,
                           output logic saw_rd, output logic saw_wr, output logic both);
        int  beat;
        bit  done;
        wseen = '0; aseen = '0; ncyc = 0; nresp = 0; extra = 0;
        saw_rd = 0; saw_wr = 0; both = 0; beat = 0; done = 0;
        @(negedge clk);
        line_read_i = rd; line_write_i = wr; line_addr_i = addr;
        line_wdata_i = wline; mem_resp_i = 0;
        while (!done && ncyc < 200) begin
            @(negedge clk);
            ncyc++;
            line_addr_i  = $urandom;
            line_wdata_i = rand256();
            if (mem_read_o && mem_write_o) both = 1;
            if (mem_read_o)  saw_rd = 1;
            if (mem_write_o) saw_wr = 1;
            if (mem_read_o || mem_write_o) aseen = mem_addr_o;
            mem_rdata_i = {$urandom, $urandom};
            if (line_resp_o) begin
                nresp++;
                done = 1;
                mem_resp_i = 1'b1;
            end else if (mem_read_o || mem_write_o) begin
                mem_resp_i = ($urandom_range(99) >= stall_pct);
                if (mem_resp_i && beat < 4) begin
                    if (mem_write_o) wseen[64*beat +: 64] = mem_wdata_o;
                    mem_rdata_i = rline[64*beat +: 64];
                    beat++;
                end
            end else begin
                mem_resp_i = 1'($urandom_range(1));
            end
        end
        // L2 drops its request the cycle after completion; memory keeps
        // chattering to show stray acknowledges are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            line_read_i = 0; line_write_i = 0;
            if (line_resp_o || mem_read_o || mem_write_o) extra++;
            mem_resp_i  = 1'($urandom_range(1));
            mem_rdata_i = {$urandom, $urandom};
        end
        mem_resp_i = 0;
    endtask

    task automatic test_reset();
        rst = 1; line_read_i = 0; line_write_i = 0; line_addr_i = '0;
        line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 0;
        line_model = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({line_resp_o, mem_read_o, mem_write_o} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes got=%b exp=000", {line_resp_o, mem_read_o, mem_write_o});
        end
        total++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 64'h0) begin
            bad++; $display("FAIL reset_mem_bus addr=%h wdata=%h exp=0", mem_addr_o, mem_wdata_o);
        end
        total++;
        if (line_rdata_o !== 256'h0) begin
            bad++; $display("FAIL reset_rdata got=%h exp=0", line_rdata_o);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_read_nostall();
        logic [255:0] rline, wseen;
        logic [31:0]  aseen;
        int ncyc, nresp, extra;
        logic srd, swr, both;
        rline = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        do_xfer(1, 0, 32'h0000_1234, rand256(), rline, 0, wseen, aseen, ncyc, nresp, extra, srd, swr, both);
        line_model = rline;
        total++;
        if (aseen !== 32'h0000_1220) begin
            bad++; $display("FAIL read_addr got=%h exp=00001220", aseen);
        end
        // request cycle + 4 beats -> pulse visible in the 6th cycle (5 edges later)
        total++;
        if (ncyc !== 5) begin
            bad++; $display("FAIL read_latency edges=%0d exp=5", ncyc);
        end
        total++;
        if (line_rdata_o !== rline) begin
            bad++; $display("FAIL read_data got=%h exp=%h", line_rdata_o, rline);
        end
        total++;
        if (nresp !== 1 || extra !== 0 || swr !== 0) begin
            bad++; $display("FAIL read_once resp=%0d extra=%0d wr=%b exp=1,0,0", nresp, extra, swr);
        end
    endtask

    task automatic test_write_stalls();
        logic [63:0]  d[4];
        logic [6:0]   pat;
        int           acc;
        d[0] = 64'hD0D0_0000_0000_D0D0; d[1] = 64'hD1D1_1111_1111_D1D1;
        d[2] = 64'hD2D2_2222_2222_D2D2; d[3] = 64'hD3D3_3333_3333_D3D3;
        pat = 7'b1011001;  // bit i = mem_resp_i in cycle i: 1,0,0,1,1,0,1
        acc = 0;
        @(negedge clk);
        line_write_i = 1; line_addr_i = 32'h8000_0040;
        line_wdata_i = {d[3], d[2], d[1], d[0]};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            line_wdata_i = rand256();
            total++;
            if (mem_write_o !== 1'b1 || mem_wdata_o !== d[acc] || mem_addr_o !== 32'h8000_0040) begin
                bad++; $display("FAIL wstall_beat%0d wr=%b data=%h addr=%h exp=1,%h,80000040",
                                i, mem_write_o, mem_wdata_o, mem_addr_o, d[acc]);
            end
            mem_resp_i = pat[i];
            if (pat[i]) acc++;
        end
        @(negedge clk);
        mem_resp_i = 0;
        total++;
        if (line_resp_o !== 1'b1 || mem_write_o !== 1'b0) begin
            bad++; $display("FAIL wstall_done resp=%b wr=%b exp=1,0", line_resp_o, mem_write_o);
        end
        total++;
        if (line_rdata_o !== line_model) begin
            bad++; $display("FAIL wstall_rdata_kept got=%h exp=%h", line_rdata_o, line_model);
        end
        @(negedge clk);
        line_write_i = 0;
        @(negedge clk);
    endtask

    task automatic test_both_high();
        logic [255:0] wline, wseen;
        logic [31:0]  aseen;
        int ncyc, nresp, extra;
        logic srd, swr, both;
        wline = rand256();
        do_xfer(1, 1, 32'h0ABC_DEFF, wline, rand256(), 30, wseen, aseen, ncyc, nresp, extra, srd, swr, both);
        total++;
        if (srd !== 1'b0 || swr !== 1'b1 || both !== 1'b0) begin
            bad++; $display("FAIL both_high rd=%b wr=%b both=%b exp=0,1,0", srd, swr, both);
        end
        total++;
        if (wseen !== wline || aseen !== 32'h0ABC_DEE0) begin
            bad++; $display("FAIL both_high_data got=%h addr=%h exp=%h 0abcdee0", wseen, aseen, wline);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [255:0] rline, wseen;
        logic [31:0]  aseen;
        int ncyc, nresp, extra;
        logic srd, swr, both;
        @(negedge clk);
        line_read_i = 1; line_addr_i = 32'h0000_5000; mem_resp_i = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp_i = 1; mem_rdata_i = {$urandom, $urandom};
        end
        @(negedge clk);
        mem_resp_i = 0;
        total++;
        if (mem_read_o !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre rd=%b exp=1", mem_read_o);
        end
        #1 rst = 1;
        #1;
        total++;
        if (mem_read_o !== 1'b0 || line_resp_o !== 1'b0 || line_rdata_o !== 256'h0) begin
            bad++; $display("FAIL rstmid_async rd=%b resp=%b rdata=%h exp=0,0,0",
                            mem_read_o, line_resp_o, line_rdata_o);
        end
        line_read_i = 0;
        line_model = '0;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        total++;
        if (line_resp_o !== 1'b0 || mem_read_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet resp=%b rd=%b exp=0,0", line_resp_o, mem_read_o);
        end
        rline = rand256();
        do_xfer(1, 0, 32'h0000_5010, '0, rline, 25, wseen, aseen, ncyc, nresp, extra, srd, swr, both);
        line_model = rline;
        total++;
        if (nresp !== 1 || line_rdata_o !== rline) begin
            bad++; $display("FAIL rstmid_next resp=%0d got=%h exp=1 %h", nresp, line_rdata_o, rline);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] rline, wline, wseen;
        logic [31:0]  aseen;
        int ncyc, nresp, extra, tx;
        logic srd, swr, both;
        rline = rand256(); wline = rand256(); tx = 0;
        do_xfer(1, 0, 32'h1000_0000, '0, rline, 0, wseen, aseen, ncyc, nresp, extra, srd, swr, both);
        tx += nresp + extra;
        line_model = rline;
        do_xfer(0, 1, 32'h2000_0020, wline, rand256(), 0, wseen, aseen, ncyc, nresp, extra, srd, swr, both);
        tx += nresp + extra;
        total++;
        if (tx !== 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", tx);
        end
        total++;
        if (wseen !== wline || srd !== 1'b0) begin
            bad++; $display("FAIL b2b_write got=%h rd=%b exp=%h 0", wseen, srd, wline);
        end
        total++;
        if (line_rdata_o !== line_model) begin
            bad++; $display("FAIL b2b_rdata_kept got=%h exp=%h", line_rdata_o, line_model);
        end
    endtask

    task automatic test_random();
        logic [255:0] rline, wline, wseen;
        logic [31:0]  addr, aseen;
        int ncyc, nresp, extra;
        logic srd, swr, both, is_wr;
        for (int t = 0; t < 12; t++) begin
            is_wr = 1'($urandom_range(1));
            addr  = $urandom;
            rline = rand256(); wline = rand256();
            do_xfer(!is_wr, is_wr, addr, wline, rline, $urandom_range(60),
                    wseen, aseen, ncyc, nresp, extra, srd, swr, both);
            if (!is_wr) line_model = rline;
            total++;
            if (nresp !== 1 || extra !== 0 || both !== 1'b0 || srd !== !is_wr || swr !== is_wr) begin
                bad++; $display("FAIL rand%0d_proto resp=%0d extra=%0d both=%b rd=%b wr=%b wr_req=%b",
                                t, nresp, extra, both, srd, swr, is_wr);
            end
            total++;
            if (aseen !== {addr[31:5], 5'b0}) begin
                bad++; $display("FAIL rand%0d_addr got=%h exp=%h", t, aseen, {addr[31:5], 5'b0});
            end
            total++;
            if (line_rdata_o !== line_model || (is_wr && wseen !== wline)) begin
                bad++; $display("FAIL rand%0d_data rdata=%h exp=%h wseen=%h wexp=%h",
                                t, line_rdata_o, line_model, wseen, wline);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_nostall();
        test_write_stalls();
        test_both_high();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Converts the L2 cache's 256-bit cacheline memory port into the 64-bit, 4-beat burst protocol of the physical DRAM model.
- Sits directly downstream of the L2 cache, between the L2 pmem port and the external memory.
- The L2 sees a single-transaction line interface. The adaptor serialises writes into beats and assembles read beats into a line.

Parameters:
- LINE_W, 256, cacheline width in bits.
- BURST_W, 64, memory beat width in bits. BEATS = LINE_W/BURST_W = 4.
- OFFSET_W, 5, byte-offset bits cleared when forming the burst address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- line_read_i  in  1  L2 line read request; held high until line_resp_o.
- line_write_i  in  1  L2 line write request; held high until line_resp_o.
- line_addr_i  in  32  line address from L2.
- line_wdata_i  in  LINE_W  line to write; stable while line_write_i is high.
- line_rdata_o  out  LINE_W  assembled read line.
- line_resp_o  out  1  one-cycle completion pulse.
- mem_read_o  out  1  burst read request to memory.
- mem_write_o  out  1  burst write request to memory.
- mem_addr_o  out  32  burst base address.
- mem_wdata_o  out  BURST_W  current write beat.
- mem_rdata_i  in  BURST_W  read beat from memory.
- mem_resp_i  in  1  per-beat acknowledge from memory.

Behaviour:
- Reset (async, immediate): state=IDLE, beat counter=0, all outputs 0 including line_rdata_o.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples the request. line_write_i takes priority if both requests are high; both high is illegal from L2 but deterministic.
  - On a request: latch {line_addr_i[31:5],5'b0} into the address register, latch line_wdata_i (write) into a 256-bit shift/hold register, clear the beat counter.
  - Go to WRITE or READ on the next edge.
  - mem_resp_i in IDLE or DONE is ignored.
- READ:
  - mem_read_o=1 and mem_addr_o=latched address for the whole state.
  - Each cycle with mem_resp_i=1 stores mem_rdata_i into line bits [64k+63:64k], k = beat counter, then increments k.
  - Cycles with mem_resp_i=0 are stalls, including gaps between beats; the counter holds.
  - When beat k=3 is accepted, go to DONE. mem_read_o drops in DONE.
- WRITE:
  - mem_write_o=1, mem_addr_o=latched address, mem_wdata_o = beat k = latched line bits [64k+63:64k].
  - Each mem_resp_i=1 accepts the current beat and advances k; mem_wdata_o shows the next beat in the following cycle.
  - After beat 3 is accepted, go to DONE.
- DONE:
  - line_resp_o=1 for exactly one cycle; then go to IDLE.
  - For reads, line_rdata_o is valid in this cycle and holds its value until the next read's DONE. Writes do not modify line_rdata_o.
- Latency: with no memory stalls, request-to-line_resp_o = 1 (IDLE→xfer) + 4 beats + 1 (DONE) = 6 cycles.
- Request clearing: the L2 deasserts its request on the cycle after line_resp_o. The adaptor is back in IDLE then and does not start a new transaction from a stale request, because it samples only in IDLE on the cycle after DONE.
- Latching: line_addr_i and line_wdata_i changes after acceptance have no effect; latched copies are used.
- Reset mid-burst: mem_read_o/mem_write_o drop asynchronously, the partial line is discarded, and no line_resp_o is produced.
- Exactly one of mem_read_o or mem_write_o is high at any time; never both.
- Counter is 2 bits and wraps naturally; the wrap from 3 to 0 coincides with the transition to DONE.

Test Plan:
- Read, no stalls: line_addr_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive mem_resp_i cycles. Required: mem_addr_o=0x0000_1220, line_resp_o 6 cycles after the request, line_rdata_o={0x44..44,0x33..33,0x22..22,0x11..11}.
- Write with stalls: line_wdata_i=256'h{D3,D2,D1,D0} at 0x8000_0040, mem_resp_i pattern 1,0,0,1,1,0,1. Required: mem_wdata_o shows D0,D1,D1,D1,D2,D3,D3 across those cycles, and line_resp_o follows the 4th accept.
- Both line_read_i and line_write_i high: a write burst is issued, mem_read_o stays 0 throughout.
- Reset asserted after beat 2 of a read: mem_read_o falls in the same cycle (async), no line_resp_o, and line_rdata_o=0. A next read completes normally.
- Back-to-back: read then write with the request deasserted one cycle after line_resp_o. Required: exactly two transactions, line_rdata_o unchanged by the write, and spurious mem_resp_i=1 in IDLE ignored.
